wbu_writeback: RTL and testbench

- Writeback stage directly upstream of the register file write port in the NPC single-issue core.
- Accepts one retiring instruction per handshake from the execute stage.
- For loads, issues a word-aligned memory read and waits for the response, then extracts and sign- or zero-extends the addressed byte, half or word.
- Drives the register-file write port for exactly one cycle per retired instruction.

---
 rtl/npc_pkg.sv | 37 +++
 rtl/wbu_load_align.sv | 24 ++
 rtl/wbu_writeback.sv | 152 +++++++++++++++
 tb/tb_wbu_writeback.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared NPC core types: load-size encodings, writeback FSM states and the
// retire packet captured by the writeback stage.
package npc_pkg;

  localparam int NPC_XLEN   = 32;
  localparam int NPC_REG_AW = 5;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;

  typedef enum logic [1:0] {
    WBU_IDLE  = 2'd0,
    WBU_REQ   = 2'd1,
    WBU_WAIT  = 2'd2,
    WBU_WRITE = 2'd3
  } wbu_state_t;

  typedef struct packed {
    logic [NPC_REG_AW-1:0] rd;
    logic                  rd_wen;
    logic [NPC_XLEN-1:0]   result;
    logic                  is_load;
    logic [1:0]            ld_size;
    logic                  ld_unsigned;
  } retire_pkt_t;

  // Size encoding 2'b11 behaves as a word access.
  function automatic logic ld_misaligned(logic [1:0] size, logic [1:0] addr);
    case (size)
      LD_B:    return 1'b0;
      LD_H:    return addr[0];
      default: return (addr != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/wbu_load_align.sv
// Load data alignment: selects the addressed byte/half of a read word and
// sign- or zero-extends it.
module wbu_load_align
  import npc_pkg::*;
(
  input  logic [NPC_XLEN-1:0] word_i,
  input  logic [1:0]          addr_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  output logic [NPC_XLEN-1:0] data_o
);

  logic [NPC_XLEN-1:0] shifted;

  always_comb begin
    shifted = word_i >> {addr_i, 3'b000};
    case (size_i)
      LD_B:    data_o = {{(NPC_XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
      LD_H:    data_o = {{(NPC_XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wbu_writeback.sv
// NPC writeback stage: retires one instruction per handshake, performs loads
// through a request/response port. Optional counters under WBU_RETIRE_CNT_EN.
module wbu_writeback
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  retire,
`ifdef WBU_RETIRE_CNT_EN
  output logic [63:0]           retire_cnt,
  output logic [31:0]           load_cnt,
`endif
  output logic                  misalign
);

  wbu_state_t            state_q, state_d;
  retire_pkt_t           pkt_q, pkt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  misal_q, misal_d;
  logic [DATA_WIDTH-1:0] aligned;

  wbu_load_align u_align (
    .word_i     (mem_rsp_data),
    .addr_i     (pkt_q.result[1:0]),
    .size_i     (pkt_q.ld_size),
    .unsigned_i (pkt_q.ld_unsigned),
    .data_o     (aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WBU_IDLE;
      pkt_q   <= '0;
      data_q  <= '0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      data_q  <= data_d;
      misal_q <= misal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    data_d  = data_q;
    misal_d = misal_q;
    case (state_q)
      WBU_IDLE, WBU_WRITE: begin
        if (in_valid) begin
          pkt_d.rd          = in_rd;
          pkt_d.rd_wen      = in_rd_wen;
          pkt_d.result      = in_result;
          pkt_d.is_load     = in_is_load;
          pkt_d.ld_size     = in_ld_size;
          pkt_d.ld_unsigned = in_ld_unsigned;
          data_d            = in_result;
          misal_d           = 1'b0;
          if (!in_is_load) begin
            state_d = WBU_WRITE;
          end else if (ld_misaligned(in_ld_size, in_result[1:0])) begin
            // Dropped load still retires through WRITE, flagged and without a write.
            state_d = WBU_WRITE;
            misal_d = 1'b1;
          end else begin
            state_d = WBU_REQ;
          end
        end else begin
          state_d = WBU_IDLE;
        end
      end
      WBU_REQ: begin
        if (mem_req_ready) state_d = WBU_WAIT;
      end
      WBU_WAIT: begin
        if (mem_rsp_valid) begin
          data_d  = aligned;
          state_d = WBU_WRITE;
        end
      end
      default: state_d = WBU_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    rf_wen        = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    retire        = 1'b0;
    misalign      = 1'b0;
    case (state_q)
      WBU_IDLE: in_ready = 1'b1;
      WBU_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {pkt_q.result[DATA_WIDTH-1:2], 2'b00};
      end
      WBU_WRITE: begin
        in_ready = 1'b1;
        retire   = 1'b1;
        misalign = misal_q;
        if (!misal_q) begin
          rf_wen   = pkt_q.rd_wen && (pkt_q.rd != '0);
          rf_waddr = pkt_q.rd;
          rf_wdata = data_q;
        end
      end
      default: ;
    endcase
  end

`ifdef WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;
  logic [31:0] load_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
      load_cnt_q   <= '0;
    end else if (state_q == WBU_WRITE) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
      if (pkt_q.is_load && !misal_q) load_cnt_q <= load_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign load_cnt   = load_cnt_q;
`endif

endmodule

// File: tb/tb_wbu_writeback.sv
// Directed bench for wbu_writeback: vector table plus hand-written sequences
// for back-to-back retire, stalled memory and reset during a load.
module tb_wbu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic        misalign;
`ifdef WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
  logic [31:0] load_cnt;
`endif

  always #5 clk = ~clk;

  wbu_writeback dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rd          (in_rd),
    .in_rd_wen      (in_rd_wen),
    .in_result      (in_result),
    .in_is_load     (in_is_load),
    .in_ld_size     (in_ld_size),
    .in_ld_unsigned (in_ld_unsigned),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .retire         (retire),
`ifdef WBU_RETIRE_CNT_EN
    .retire_cnt     (retire_cnt),
    .load_cnt       (load_cnt),
`endif
    .misalign       (misalign)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] res;
    logic        ld;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] rsp;
    int          stall;
    int          dly;
    logic        ewen;
    logic [31:0] ewdata;
    logic        emis;
  } vec_t;

  vec_t vecs[16];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 0; in_rd = 0; in_rd_wen = 0; in_result = 0;
    in_is_load = 0; in_ld_size = 0; in_ld_unsigned = 0;
  endtask

  task automatic drive_instr(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                             input logic ld, input logic [1:0] sz, input logic uns);
    in_valid = 1; in_rd = rd; in_rd_wen = wen; in_result = res;
    in_is_load = ld; in_ld_size = sz; in_ld_unsigned = uns;
  endtask

  // Issue one instruction and act as memory until it retires.
  task automatic run_vec(input int idx, input vec_t v);
    int   stall, dly, lat, exp_lat;
    bit   go_wait, in_wait, rsp_sent, done, seen_req;
    logic [31:0] exp_addr;
    stall = v.stall; dly = 0; go_wait = 0; in_wait = 0; rsp_sent = 0; done = 0; seen_req = 0;
    exp_addr = {v.res[31:2], 2'b00};
    exp_lat  = (v.ld && !v.emis) ? 3 + v.stall + v.dly : 1;
    lat = 0;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", idx), in_ready, 1);
    drive_instr(v.rd, v.wen, v.res, v.ld, v.sz, v.uns);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      drive_idle();
      mem_req_ready = 0;
      mem_rsp_valid = 0;
      if (retire) begin
        lat = k;
        done = 1;
        break;
      end
      if (go_wait) begin in_wait = 1; go_wait = 0; dly = v.dly; end
      if (in_wait && !rsp_sent) begin
        if (dly == 0) begin mem_rsp_valid = 1; mem_rsp_data = v.rsp; rsp_sent = 1; end
        else dly--;
      end
      if (mem_req_valid) begin
        seen_req = 1;
        chk($sformatf("v%0d req_addr", idx), mem_req_addr, exp_addr);
        if (stall == 0) begin mem_req_ready = 1; go_wait = 1; end
        else stall--;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL v%0d timeout: no retire within 40 cycles", idx);
    end else begin
      chk($sformatf("v%0d latency", idx), lat, exp_lat);
      chk($sformatf("v%0d rf_wen", idx), rf_wen, v.ewen);
      chk($sformatf("v%0d misalign", idx), misalign, v.emis);
      if (!v.emis) begin
        chk($sformatf("v%0d rf_waddr", idx), rf_waddr, v.rd);
        chk($sformatf("v%0d rf_wdata", idx), rf_wdata, v.ewdata);
      end else begin
        chk($sformatf("v%0d no_mem_req", idx), seen_req, 0);
      end
      @(negedge clk);
      chk($sformatf("v%0d retire_pulse", idx), retire, 0);
      chk($sformatf("v%0d rf_wen_after", idx), rf_wen, 0);
      chk($sformatf("v%0d in_ready_after", idx), in_ready, 1);
    end
  endtask

  initial begin
    //             rd   wen  res            ld sz     uns rsp            st dl ewen ewdata        emis
    vecs[0]  = '{5'd5,  1, 32'hDEADBEEF, 0, 2'b10, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0};
    vecs[1]  = '{5'd0,  1, 32'h12345678, 0, 2'b10, 0, 32'h0,        0, 0, 0, 32'h12345678, 0};
    vecs[2]  = '{5'd7,  0, 32'h0000AAAA, 0, 2'b10, 0, 32'h0,        0, 0, 0, 32'h0000AAAA, 0};
    vecs[3]  = '{5'd10, 1, 32'h80000003, 1, 2'b00, 0, 32'h80FF0011, 0, 0, 1, 32'hFFFFFF80, 0};
    vecs[4]  = '{5'd10, 1, 32'h80000003, 1, 2'b00, 1, 32'h80FF0011, 0, 0, 1, 32'h00000080, 0};
    vecs[5]  = '{5'd11, 1, 32'h80000002, 1, 2'b01, 0, 32'h80010000, 3, 2, 1, 32'hFFFF8001, 0};
    vecs[6]  = '{5'd12, 1, 32'h80000006, 1, 2'b10, 0, 32'h0,        0, 0, 0, 32'h0,        1};
    vecs[7]  = '{5'd13, 1, 32'h80000002, 1, 2'b01, 1, 32'h80010000, 0, 1, 1, 32'h00008001, 0};
    vecs[8]  = '{5'd14, 1, 32'h00000081, 1, 2'b01, 0, 32'h0,        0, 0, 0, 32'h0,        1};
    vecs[9]  = '{5'd31, 1, 32'h00000100, 1, 2'b10, 0, 32'hCAFEF00D, 1, 0, 1, 32'hCAFEF00D, 0};
    vecs[10] = '{5'd1,  1, 32'h00000001, 1, 2'b00, 0, 32'h00007F00, 0, 0, 1, 32'h0000007F, 0};
    vecs[11] = '{5'd2,  1, 32'h00000004, 1, 2'b11, 0, 32'h11223344, 0, 0, 1, 32'h11223344, 0};
    vecs[12] = '{5'd2,  1, 32'h00000002, 1, 2'b11, 0, 32'h0,        0, 0, 0, 32'h0,        1};
    vecs[13] = '{5'd3,  1, 32'h00000000, 1, 2'b01, 1, 32'h1234ABCD, 0, 0, 1, 32'h0000ABCD, 0};
    vecs[14] = '{5'd4,  1, 32'h00000002, 1, 2'b00, 0, 32'h00800000, 1, 3, 1, 32'hFFFFFF80, 0};
    vecs[15] = '{5'd0,  1, 32'h00000000, 1, 2'b10, 0, 32'h55AA55AA, 0, 0, 0, 32'h55AA55AA, 0};

    rst_n = 0;
    drive_idle();
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst mem_req_addr", mem_req_addr, 0);
    chk("rst rf_wen", rf_wen, 0);
    chk("rst rf_waddr", rf_waddr, 0);
    chk("rst rf_wdata", rf_wdata, 0);
    chk("rst retire", retire, 0);
    chk("rst misalign", misalign, 0);
`ifdef WBU_RETIRE_CNT_EN
    chk("rst retire_cnt", retire_cnt, 0);
    chk("rst load_cnt", load_cnt, 0);
`endif
    rst_n = 1;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Back-to-back ALU ops with in_valid held: one write per cycle.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d rf_wen", i - 1), rf_wen, 1);
        chk($sformatf("b2b%0d rf_waddr", i - 1), rf_waddr, 5'd20 + 5'(i - 1));
        chk($sformatf("b2b%0d rf_wdata", i - 1), rf_wdata, 32'hA000_0000 + 32'(i - 1));
        chk($sformatf("b2b%0d in_ready", i - 1), in_ready, 1);
      end
      if (i < 4) drive_instr(5'd20 + 5'(i), 1, 32'hA000_0000 + 32'(i), 0, 2'b10, 0);
      else drive_idle();
    end
    @(negedge clk);
    chk("b2b end retire", retire, 0);
    chk("b2b end rf_wen", rf_wen, 0);

    // Reset while waiting for a load response, then a stray response.
    @(negedge clk);
    drive_instr(5'd9, 1, 32'h0000_0200, 1, 2'b10, 0);
    @(negedge clk);
    drive_idle();
    chk("rstw req_valid", mem_req_valid, 1);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    chk("rstw in_wait", in_ready, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    mem_rsp_valid = 1; mem_rsp_data = 32'hBAD0BAD0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rstw%0d in_ready", k), in_ready, 1);
      chk($sformatf("rstw%0d rf_wen", k), rf_wen, 0);
      chk($sformatf("rstw%0d retire", k), retire, 0);
      chk($sformatf("rstw%0d req_valid", k), mem_req_valid, 0);
      @(negedge clk);
      mem_rsp_valid = 0;
    end

`ifdef WBU_RETIRE_CNT_EN
    chk("cnt after reset", retire_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      drive_instr(5'd6, 1, 32'(i), 0, 2'b10, 0);
      @(negedge clk);
    end
    drive_idle();
    @(negedge clk);
    chk("cnt after 10", retire_cnt, 10);
    chk("load_cnt zero", load_cnt, 0);
    run_vec(100, vecs[3]);
    run_vec(101, vecs[6]);
    chk("cnt after load", retire_cnt, 12);
    chk("load_cnt one", load_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
